// File: rtl/conv_pool_quant.sv
// Pooling/requantization stage behind the 1-D convolution core: optional ReLU,
// non-overlapping max-pool over POOL_N samples, floor shift and saturation to OUT_W.
module conv_pool_quant #(
  parameter int IN_W    = 21,
  parameter int OUT_W   = 8,
  parameter int CONV_N  = 97,
  parameter int POOL_N  = 2,
  parameter int SHIFT   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  input  logic signed [IN_W-1:0]  s_data_in_y,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output logic signed [OUT_W-1:0] m_data_out_z,
  output logic                    m_last_z
);

  localparam int WIN_W = (POOL_N > 1) ? $clog2(POOL_N) : 1;
  localparam int FRM_W = (CONV_N > 1) ? $clog2(CONV_N) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL_N - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(CONV_N - 1);
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-(2 ** (OUT_W - 1)));

  logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
  logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic signed [IN_W-1:0]  max_q, max_d;
  logic                    valid_q, valid_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    last_q, last_d;

  logic                    accept, xfer, frame_end, close;
  logic signed [IN_W-1:0]  relu_v, pool_m, shifted;
  logic signed [OUT_W-1:0] sat_v;

  // Single output register: a new sample may enter whenever that register is
  // empty or is being drained in this same cycle.
  assign s_ready_y = !valid_q || m_ready_z;
  assign accept    = s_valid_y && s_ready_y;
  assign xfer      = valid_q && m_ready_z;
  assign frame_end = (frame_cnt_q == FRM_LAST);
  // The last sample of a frame closes its window even when the window is partial.
  assign close     = (win_cnt_q == WIN_LAST) || frame_end;

  always_comb begin : datapath
    relu_v  = (RELU_EN && s_data_in_y[IN_W-1]) ? '0 : s_data_in_y;
    pool_m  = ((win_cnt_q == '0) || (relu_v > max_q)) ? relu_v : max_q;
    shifted = pool_m >>> SHIFT;
    if (shifted > SAT_HI) begin
      sat_v = SAT_HI[OUT_W-1:0];
    end else if (shifted < SAT_LO) begin
      sat_v = SAT_LO[OUT_W-1:0];
    end else begin
      sat_v = shifted[OUT_W-1:0];
    end
  end

  always_comb begin : next_state
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
    win_cnt_d   = win_cnt_q;
    frame_cnt_d = frame_cnt_q;
    max_d       = max_q;
    valid_d     = valid_q;
    data_d      = data_q;
    last_d      = last_q;

    if (xfer) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
      if (close) begin
        // Overrides the drain above, so back-to-back results leave no bubble.
        data_d    = sat_v;
        last_d    = frame_end;
        valid_d   = 1'b1;
        win_cnt_d = '0;
      end else begin
        max_d     = pool_m;
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them update together.
    if (reset) begin
      win_cnt_q   <= '0;
      frame_cnt_q <= '0;
      max_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      max_q       <= max_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign m_valid_z    = valid_q;
  assign m_data_out_z = data_q;
  assign m_last_z     = last_q;

endmodule

// File: tb/tb_conv_pool_quant.sv
// Directed bench for conv_pool_quant: one ReLU and one linear instance, a vector table
// for single windows, and hand-written frame/backpressure/reset sequences.
module tb_conv_pool_quant;

  localparam int IN_W   = 21;
  localparam int OUT_W  = 8;
  localparam int CONV_N = 97;
  localparam int SHIFT  = 8;
  localparam int N_OUT  = (CONV_N + 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic                    s_valid_r, s_valid_l, m_ready;
  logic signed [IN_W-1:0]  s_data;
  logic                    r_s_ready, l_s_ready, r_mv, l_mv, r_last, l_last;
  logic signed [OUT_W-1:0] r_z, l_z;

  conv_pool_quant #(.RELU_EN(1'b1)) u_relu (
    .clk(clk), .reset(reset),
    .s_valid_y(s_valid_r), .s_ready_y(r_s_ready), .s_data_in_y(s_data),
    .m_valid_z(r_mv), .m_ready_z(m_ready), .m_data_out_z(r_z), .m_last_z(r_last)
  );

  conv_pool_quant #(.RELU_EN(1'b0)) u_lin (
    .clk(clk), .reset(reset),
    .s_valid_y(s_valid_l), .s_ready_y(l_s_ready), .s_data_in_y(s_data),
    .m_valid_z(l_mv), .m_ready_z(m_ready), .m_data_out_z(l_z), .m_last_z(l_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for one window of up to two samples, written from the arithmetic definition.
  function automatic int model_q(input int a, input int b, input bit has_b, input bit relu);
    int va, vb, m;
    va = (relu && a < 0) ? 0 : a;
    vb = (relu && b < 0) ? 0 : b;
    m  = va;
    if (has_b && vb > m) m = vb;
    m = m >>> SHIFT;
    if (m > 127)  m = 127;
    if (m < -128) m = -128;
    return m;
  endfunction

  function automatic int sample_val(input int pat, input int f, input int idx);
    if (pat == 0) return idx * 256;
    return ((idx * 37 + f * 53) % 211 - 90) * 300;
  endfunction

  // Streams whole frames into the ReLU instance and checks every output transfer.
  task automatic run_stream(input int nframes, input int pat, input int fbase,
                            input bit rand_ready, input string tag);
    int exp_q[$];
    bit last_q[$];
    int k, total, budget, nout;
    for (int f = 0; f < nframes; f++) begin
      for (int w = 0; 2 * w < CONV_N; w++) begin
        int a, b;
        bit hb;
        a  = sample_val(pat, fbase + f, 2 * w);
        hb = (2 * w + 1 < CONV_N);
        b  = hb ? sample_val(pat, fbase + f, 2 * w + 1) : 0;
        exp_q.push_back(model_q(a, b, hb, 1'b1));
        last_q.push_back(2 * w + 2 >= CONV_N);
      end
    end
    k = 0; nout = 0; budget = 0;
    total = nframes * CONV_N;
    while ((k < total || exp_q.size() > 0) && budget < 1500 * nframes) begin
      m_ready   = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_valid_r = (k < total);
      s_data    = IN_W'(sample_val(pat, fbase + k / CONV_N, k % CONV_N));
      #1;
      if (r_mv && m_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s_extra_out", tag), 1, 0);
        end else begin
          check($sformatf("%s_z%0d", tag, nout), int'(r_z), exp_q.pop_front());
          check($sformatf("%s_last%0d", tag, nout), int'(r_last), int'(last_q.pop_front()));
        end
        nout++;
      end
      if (s_valid_r && r_s_ready) k++;
      step();
      budget++;
    end
    s_valid_r = 1'b0;
    m_ready   = 1'b1;
    check($sformatf("%s_pending_after_budget", tag), exp_q.size(), 0);
    check($sformatf("%s_out_count", tag), nout, nframes * N_OUT);
  endtask

  typedef struct {
    bit lin;
    int y0;
    int y1;
    int ez;
  } vec_t;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   gv, gz, gl;

    vecs[0]  = '{1'b0, 256, 512, 2};
    vecs[1]  = '{1'b0, 40000, -5, 127};
    vecs[2]  = '{1'b0, -1000, -1, 0};
    vecs[3]  = '{1'b0, 511, 255, 1};
    vecs[4]  = '{1'b0, -9000, 32767, 127};
    vecs[5]  = '{1'b1, -300, -70000, -2};
    vecs[6]  = '{1'b1, -70000, -70000, -128};
    vecs[7]  = '{1'b1, -1, -1, -1};
    vecs[8]  = '{1'b1, -257, -600, -2};
    vecs[9]  = '{1'b1, 1000, 10, 3};
    vecs[10] = '{1'b1, -32768, -40000, -128};
    vecs[11] = '{1'b1, -32769, -50000, -128};

    reset = 1'b1; s_valid_r = 1'b0; s_valid_l = 1'b0; m_ready = 1'b1; s_data = '0;
    step(); step();
    reset = 1'b0;
    check("rst_r_valid", int'(r_mv), 0);
    check("rst_r_z", int'(r_z), 0);
    check("rst_r_last", int'(r_last), 0);
    check("rst_l_valid", int'(l_mv), 0);
    check("rst_r_s_ready", int'(r_s_ready), 1);

    // Single windows: latency, pooling, ReLU, floor and both saturation limits.
    for (int i = 0; i < 12; i++) begin
      s_valid_r = !vecs[i].lin;
      s_valid_l = vecs[i].lin;
      s_data    = IN_W'(vecs[i].y0);
      step();
      gv = vecs[i].lin ? int'(l_mv) : int'(r_mv);
      check($sformatf("vec%0d_no_early_valid", i), gv, 0);
      s_data = IN_W'(vecs[i].y1);
      step();
      s_valid_r = 1'b0;
      s_valid_l = 1'b0;
      gv = vecs[i].lin ? int'(l_mv) : int'(r_mv);
      gz = vecs[i].lin ? int'(l_z) : int'(r_z);
      gl = vecs[i].lin ? int'(l_last) : int'(r_last);
      check($sformatf("vec%0d_valid", i), gv, 1);
      check($sformatf("vec%0d_z", i), gz, vecs[i].ez);
      check($sformatf("vec%0d_last", i), gl, 0);
      step();
      gv = vecs[i].lin ? int'(l_mv) : int'(r_mv);
      check($sformatf("vec%0d_drained", i), gv, 0);
    end

    // Backpressure: held output, stalled input, nothing lost or duplicated.
    reset = 1'b1; step(); reset = 1'b0;
    m_ready = 1'b0; s_valid_r = 1'b1;
    s_data = IN_W'(256); step();
    s_data = IN_W'(512); step();
    s_data = IN_W'(768);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_s_ready", c), int'(r_s_ready), 0);
      check($sformatf("bp%0d_valid", c), int'(r_mv), 1);
      check($sformatf("bp%0d_z", c), int'(r_z), 2);
      step();
    end
    m_ready = 1'b1;
    #1;
    check("bp_release_s_ready", int'(r_s_ready), 1);
    step();
    check("bp_after_xfer_valid", int'(r_mv), 0);
    s_data = IN_W'(1024); step();
    s_valid_r = 1'b0;
    check("bp_next_valid", int'(r_mv), 1);
    check("bp_next_z", int'(r_z), 4);
    step();

    // Full-throughput ramp frames, then randomly throttled frames.
    reset = 1'b1; step(); reset = 1'b0;
    run_stream(2, 0, 0, 1'b0, "ramp");
    run_stream(3, 1, 0, 1'b1, "rand");

    // Reset with a window open must discard it and realign the frame.
    s_valid_r = 1'b1;
    s_data = IN_W'(1000); step();
    s_data = IN_W'(2000); step();
    s_data = IN_W'(3000); step();
    check("pre_rst_z", int'(r_z), 7);
    s_valid_r = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_valid", int'(r_mv), 0);
    check("midrst_z", int'(r_z), 0);
    check("midrst_last", int'(r_last), 0);
    run_stream(1, 1, 5, 1'b1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
